md5_match_sink: RTL and testbench

- Terminating end of the MD5 hash pipeline; consumes the final-round a/b/c/d plus message stream (valid-qualified, no backpressure).
- Adds the MD5 initial values, forms the 128-bit digest and compares it against a programmed target.
- Queues matching 19-character messages in a small FIFO and serializes them byte-by-byte to the host link (UART/byte TX) over a valid/ready handshake.
- Counts hashes checked and flags dropped matches.

---
 rtl/md5_pkg.sv | 22 ++
 rtl/msg_fifo.sv | 53 +++++
 rtl/md5_match_sink.sv | 151 +++++++++++++++
 tb/tb_md5_match_sink.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared constants, helpers and TX state encoding for the MD5 match sink.
// The message length is fixed by the 152-bit message ports.
package md5_pkg;

    localparam logic [31:0] A0 = 32'h67452301;
    localparam logic [31:0] B0 = 32'hefcdab89;
    localparam logic [31:0] C0 = 32'h98badcfe;
    localparam logic [31:0] D0 = 32'h10325476;

    localparam int MSG_BYTES = 19;
    localparam int MSG_W     = 8 * MSG_BYTES;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// Synchronous FIFO for matched messages. A pop on a full FIFO frees the slot
// in the same cycle, so a simultaneous push is accepted.
module msg_fifo #(
    parameter int WIDTH = 152,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_CNT);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign rd_data   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/md5_match_sink.sv
// Final MD5 stage: adds the IVs, compares the digest to the target, queues
// matching messages and streams them out one byte at a time.
module md5_match_sink
    import md5_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  a_in,
    input  logic [31:0]  b_in,
    input  logic [31:0]  c_in,
    input  logic [31:0]  d_in,
    input  logic [151:0] m_in,
    input  logic         valid_in,
    input  logic [127:0] target_hash,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         match_pulse,
    output logic         overflow,
    output logic [31:0]  hash_count,
    input  logic         clear,
    output logic [0:0]   tx_state_dbg
);
    // Handshake: a byte moves when tx_valid && tx_ready at a rising edge;
    // tx_data/tx_valid hold while tx_valid && !tx_ready. No input backpressure.
    localparam logic [4:0] LAST_IDX = 5'(MSG_BYTES - 1);

    logic             r_valid_s1;
    logic [31:0]      r_a, r_b, r_c, r_d;
    logic [MSG_W-1:0] r_m_s1;
    logic             r_hit_s2;
    logic [MSG_W-1:0] r_m_s2;
    logic [31:0]      r_hash_count;
    logic             r_overflow;

    tx_state_t        r_state;
    logic [MSG_W-1:0] r_shift;
    logic [4:0]       r_byte_idx;
    logic             r_tx_valid;

    logic [127:0]     w_digest;
    logic             w_hit;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic [MSG_W-1:0] w_head;

    assign w_digest = {bswap32(r_a), bswap32(r_b), bswap32(r_c), bswap32(r_d)};
    assign w_hit    = r_valid_s1 && (w_digest == target_hash);
    assign w_pop    = (r_state == TX_SEND) && tx_ready && (r_byte_idx == LAST_IDX);
    assign w_drop   = r_hit_s2 && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_s1 <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_d        <= '0;
            r_m_s1     <= '0;
            r_hit_s2   <= 1'b0;
            r_m_s2     <= '0;
        end else begin
            r_valid_s1 <= valid_in;
            if (valid_in) begin
                r_a    <= a_in + A0;
                r_b    <= b_in + B0;
                r_c    <= c_in + C0;
                r_d    <= d_in + D0;
                r_m_s1 <= m_in;
            end
            r_hit_s2 <= w_hit;
            if (w_hit) r_m_s2 <= r_m_s1;
        end
    end

    // A drop in the same cycle as clear is still recorded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hash_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (clear)
                r_hash_count <= valid_in ? 32'd1 : 32'd0;
            else if (valid_in)
                r_hash_count <= r_hash_count + 32'd1;
            r_overflow <= w_drop || (r_overflow && !clear);
        end
    end

    msg_fifo #(
        .WIDTH (MSG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (r_hit_s2),
        .wr_data (r_m_s2),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    // The head entry stays in the FIFO until its last byte is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= TX_IDLE;
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (!w_empty) begin
                        r_shift    <= w_head;
                        r_byte_idx <= '0;
                        r_tx_valid <= 1'b1;
                        r_state    <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_ready) begin
                        if (r_byte_idx == LAST_IDX) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= TX_IDLE;
                        end else begin
                            r_shift    <= r_shift << 8;
                            r_byte_idx <= r_byte_idx + 5'd1;
                        end
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_state    <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx_data      = r_shift[MSG_W-1 -: 8];
    assign tx_valid     = r_tx_valid;
    assign match_pulse  = r_hit_s2;
    assign overflow     = r_overflow;
    assign hash_count   = r_hash_count;
    assign tx_state_dbg = r_state;

endmodule

// File: tb/tb_md5_match_sink.sv
// Randomised scoreboard bench for md5_match_sink: a digest/FIFO reference
// model queues expected pulses and bytes; a monitor checks them every cycle.
module tb_md5_match_sink;
    localparam int DEPTH = 4;
    localparam int NB    = 19;
    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  a_in, b_in, c_in, d_in;
    logic [151:0] m_in;
    logic         valid_in;
    logic [127:0] target_hash;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         match_pulse;
    logic         overflow;
    logic [31:0]  hash_count;
    logic         clear;
    logic [0:0]   tx_state_dbg;

    md5_match_sink #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_in         (a_in),
        .b_in         (b_in),
        .c_in         (c_in),
        .d_in         (d_in),
        .m_in         (m_in),
        .valid_in     (valid_in),
        .target_hash  (target_hash),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .match_pulse  (match_pulse),
        .overflow     (overflow),
        .hash_count   (hash_count),
        .clear        (clear),
        .tx_state_dbg (tx_state_dbg)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state and reference model ----------------
    int          checks = 0;
    int          errors = 0;
    int          exp_match_q[$];
    logic [7:0]  exp_q[$];
    int          model_occ = 0;
    logic [31:0] model_cnt = '0;
    bit          model_ovf = 0;
    bit          in_rst = 1;
    int          byte_in_msg = 0;
    int          bytes_seen = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_data = '0;
    int          rdy_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] bs(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic bit model_hit(input logic [31:0] a, b, c, d);
        logic [31:0] sa, sb, sc, sd;
        sa = a + IV_A;
        sb = b + IV_B;
        sc = c + IV_C;
        sd = d + IV_D;
        return {bs(sa), bs(sb), bs(sc), bs(sd)} == target_hash;
    endfunction

    task automatic make_match(output logic [31:0] a, b, c, d);
        a = bs(target_hash[127:96]) - IV_A;
        b = bs(target_hash[95:64])  - IV_B;
        c = bs(target_hash[63:32])  - IV_C;
        d = bs(target_hash[31:0])   - IV_D;
    endtask

    function automatic logic [151:0] rand_msg();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[151:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [31:0] a, b, c, d, input logic [151:0] m, input bit clr);
        @(posedge clk); #1;
        a_in = a; b_in = b; c_in = c; d_in = d; m_in = m;
        valid_in = 1'b1;
        clear = clr;
        if (clr) begin
            model_cnt = 32'd1;
            model_ovf = 0;
        end else begin
            model_cnt = model_cnt + 32'd1;
        end
        if (model_hit(a, b, c, d)) begin
            exp_match_q.push_back(cyc + 2);
            if (model_occ < DEPTH) begin
                model_occ++;
                for (int i = 0; i < NB; i++) exp_q.push_back(m[151 - 8*i -: 8]);
            end else begin
                model_ovf = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
            clear = 1'b0;
        end
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        valid_in = 1'b0;
        clear = 1'b1;
        model_cnt = '0;
        model_ovf = 0;
        idle(1);
    endtask

    task automatic match_beat(input logic [151:0] m);
        logic [31:0] a, b, c, d;
        make_match(a, b, c, d);
        drive_beat(a, b, c, d, m, 1'b0);
    endtask

    task automatic check_status(input string tag);
        @(negedge clk);
        chk({tag, "_hash_count"}, 64'(hash_count), 64'(model_cnt));
        chk({tag, "_overflow"}, 64'(overflow), 64'(model_ovf));
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_match_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_in_budget", 64'(n < budget), 64'd1);
        @(negedge clk);
        chk("tx_valid_after_drain", 64'(tx_valid), 64'd0);
    endtask

    // ---------------- tx_ready driver ----------------
    initial begin
        bit [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: tx_ready = 1'b1;
                1: begin tx_ready = pat[3 - ph]; ph = (ph + 1) % 4; end
                2: tx_ready = 1'b0;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit ep;
        forever begin
            @(negedge clk);
            if (!in_rst) begin
                ep = (exp_match_q.size() != 0) && (exp_match_q[0] == cyc);
                if (ep) void'(exp_match_q.pop_front());
                chk("match_pulse", 64'(match_pulse), 64'(ep));
                if (prev_stall) begin
                    chk("hold_valid", 64'(tx_valid), 64'd1);
                    chk("hold_data", 64'(tx_data), 64'(prev_data));
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", 64'(tx_data), 64'hFFFF);
                    end else begin
                        chk("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
                    end
                    bytes_seen++;
                    byte_in_msg++;
                    if (byte_in_msg == NB) begin
                        byte_in_msg = 0;
                        model_occ--;
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data = tx_data;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [151:0] fox;
        logic [31:0]  a, b, c, d;
        int b0;
        fox = "The quick brown fox";
        reset = 1'b1;
        valid_in = 1'b0;
        clear = 1'b0;
        a_in = '0; b_in = '0; c_in = '0; d_in = '0; m_in = '0;
        target_hash = 128'ha2004f37730b9445670a738fa0fc9ee5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_match_pulse", 64'(match_pulse), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_hash_count", 64'(hash_count), 64'd0);
        chk("rst_state", 64'(tx_state_dbg), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        in_rst = 0;

        // Non-match: a_in off by one
        make_match(a, b, c, d);
        chk("known_a_in", 64'(a), 64'hd009dda1);
        drive_beat(a + 32'd1, b, c, d, fox, 1'b0);
        idle(5);
        check_status("nomatch");
        chk("nomatch_tx_idle", 64'(tx_valid), 64'd0);

        // Match with tx_ready held high
        rdy_mode = 0;
        match_beat(fox);
        idle(1);
        wait_drain(200);
        check_status("match");

        // Backpressure 1-0-0-1
        rdy_mode = 1;
        b0 = bytes_seen;
        match_beat(fox);
        idle(1);
        wait_drain(400);
        chk("bp_byte_total", 64'(bytes_seen - b0), 64'(NB));

        // clear together with a beat
        drive_beat($urandom, $urandom, $urandom, $urandom, rand_msg(), 1'b1);
        idle(2);
        check_status("clear_with_beat");

        // Overflow: five back-to-back matches while stalled
        rdy_mode = 2;
        for (int i = 0; i < 5; i++) match_beat(rand_msg());
        idle(4);
        check_status("overflow");
        do_clear();
        check_status("after_clear");
        rdy_mode = 0;
        wait_drain(600);

        // Throughput: 1000 back-to-back beats
        do_clear();
        for (int i = 0; i < 1000; i++)
            drive_beat($urandom, $urandom, $urandom, $urandom, rand_msg(), 1'b0);
        idle(3);
        check_status("b2b_1000");
        wait_drain(2000);

        // Wrap of hash_count
        @(negedge clk);
        force dut.r_hash_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_hash_count;
        model_cnt = 32'hFFFF_FFFF;
        check_status("preload");
        drive_beat(32'h1, 32'h2, 32'h3, 32'h4, rand_msg(), 1'b0);
        idle(2);
        check_status("wrap");

        // Random mix with random tx_ready
        rdy_mode = 3;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0 && model_occ <= 1)
                match_beat(rand_msg());
            else if ($urandom_range(0, 3) == 0)
                idle(1);
            else
                drive_beat($urandom, $urandom, $urandom, $urandom, rand_msg(), 1'b0);
        end
        idle(3);
        check_status("random");
        rdy_mode = 0;
        wait_drain(2000);

        // Reset in the middle of a message
        match_beat(fox);
        idle(1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #2;
            if (byte_in_msg >= 8) break;
        end
        chk("reached_byte_8", 64'(byte_in_msg), 64'd8);
        reset = 1'b1;
        in_rst = 1;
        #1;
        chk("midrst_tx_valid", 64'(tx_valid), 64'd0);
        chk("midrst_hash_count", 64'(hash_count), 64'd0);
        chk("midrst_state", 64'(tx_state_dbg), 64'd0);
        exp_q.delete();
        exp_match_q.delete();
        model_occ = 0;
        model_cnt = '0;
        model_ovf = 0;
        byte_in_msg = 0;
        prev_stall = 0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        in_rst = 0;
        idle(4);
        @(negedge clk);
        chk("postrst_fifo_empty", 64'(tx_valid), 64'd0);
        check_status("postrst");
        match_beat(fox);
        idle(1);
        wait_drain(200);
        check_status("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
